// File: rtl/fwrisc_trace_pkg.sv
// Shared types and helpers for the fwrisc trace arbiter: beat kinds, the
// captured per-cycle bundle, and tinfo packing.
package fwrisc_trace_pkg;

  typedef enum logic [1:0] {
    INSTR = 2'd0,
    REG   = 2'd1,
    MEM   = 2'd2
  } trace_kind_e;

  // mask bit order is {mem, reg, instr}
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [5:0]  raddr;
    logic [31:0] rdata;
    logic        mwrite;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [3:0]  mstrb;
    logic [2:0]  mask;
  } trace_bundle_t;

  localparam int BUNDLE_W = $bits(trace_bundle_t);

  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_INSTR = 3'b001;
  localparam logic [2:0] SEL_REG   = 3'b010;
  localparam logic [2:0] SEL_MEM   = 3'b100;

  function automatic logic [7:0] reg_tinfo(input logic [5:0] raddr);
    return {2'b00, raddr};
  endfunction

  function automatic logic [7:0] mem_tinfo(input logic mwrite, input logic [3:0] mstrb);
    return {3'b000, mwrite, mstrb};
  endfunction

  function automatic logic [2:0] pick_beat(input logic [2:0] work);
    logic [2:0] sel;
    casez (work)
      3'b1??:  sel = SEL_MEM;
      3'b01?:  sel = SEL_REG;
      3'b001:  sel = SEL_INSTR;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fwrisc_trace_fifo.sv
// Synchronous bundle FIFO with occupancy count; the head entry is visible on
// rdata whenever the FIFO is non-empty.
module fwrisc_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  // storage write; contents are only observed while counted as occupied
  always_ff @(posedge clock) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;

endmodule

// File: rtl/fwrisc_trace_arbiter.sv
// Captures per-cycle retirement bundles into a FIFO and serialises them as
// MEM, REG, INSTR beats on one valid/ready trace stream, counting drops.
module fwrisc_trace_arbiter
  import fwrisc_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              ovf_clr,
  input  logic              ivalid,
  input  logic [31:0]       addr,
  input  logic [31:0]       instr,
  input  logic              rwrite,
  input  logic [5:0]        raddr,
  input  logic [31:0]       rdata,
  input  logic              mvalid,
  input  logic              mwrite,
  input  logic [31:0]       maddr,
  input  logic [31:0]       mdata,
  input  logic [3:0]        mstrb,
  output logic              tvalid,
  input  logic              tready,
  output logic [1:0]        tkind,
  output logic [31:0]       taddr,
  output logic [31:0]       tdata,
  output logic [7:0]        tinfo,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_bundle_t cap_s;
  trace_bundle_t head_s;
  logic          capture_s;
  logic          push_s;
  logic          pop_s;
  logic          fire_s;
  logic          drop_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic [2:0]    done_r;
  logic [2:0]    done_nxt_s;
  logic [2:0]    work_s;
  logic [2:0]    sel_s;

  // bundle assembly: fields of absent events are zeroed
  always_comb begin
    cap_s        = {BUNDLE_W{1'b0}};
    cap_s.addr   = ivalid ? addr   : 32'h0000_0000;
    cap_s.instr  = ivalid ? instr  : 32'h0000_0000;
    cap_s.raddr  = rwrite ? raddr  : 6'd0;
    cap_s.rdata  = rwrite ? rdata  : 32'h0000_0000;
    cap_s.mwrite = mvalid ? mwrite : 1'b0;
    cap_s.maddr  = mvalid ? maddr  : 32'h0000_0000;
    cap_s.mdata  = mvalid ? mdata  : 32'h0000_0000;
    cap_s.mstrb  = mvalid ? mstrb  : 4'h0;
    cap_s.mask   = {mvalid, rwrite, ivalid};
  end

  assign capture_s = en && (ivalid || rwrite || mvalid);
  assign push_s    = capture_s && (!full_s || pop_s);
  assign drop_s    = capture_s && !push_s;

  fwrisc_trace_fifo #(
    .WIDTH (BUNDLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (cap_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // working mask is the head's event mask minus beats already sent
  always_comb begin
    work_s = head_s.mask & ~done_r;
    if (empty_s) begin
      sel_s = SEL_NONE;
    end else begin
      sel_s = pick_beat(work_s);
    end
  end

  assign fire_s = tvalid && tready;
  assign pop_s  = fire_s && ((work_s & ~sel_s) == 3'b000);

  // sent-beat state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_r <= 3'b000;
    end else begin
      done_r <= done_nxt_s;
    end
  end

  // next sent-beat state; clearing on pop lets the next head start at once
  always_comb begin
    done_nxt_s = done_r;
    if (pop_s) begin
      done_nxt_s = 3'b000;
    end else if (fire_s) begin
      done_nxt_s = done_r | sel_s;
    end else begin
      done_nxt_s = done_r;
    end
  end

  // beat presentation, driven purely from stored state
  always_comb begin
    tvalid = (count_s != {CW{1'b0}});
    tkind  = INSTR;
    taddr  = 32'h0000_0000;
    tdata  = 32'h0000_0000;
    tinfo  = 8'h00;
    case (sel_s)
      SEL_MEM: begin
        tkind = MEM;
        taddr = head_s.maddr;
        tdata = head_s.mdata;
        tinfo = mem_tinfo(head_s.mwrite, head_s.mstrb);
      end
      SEL_REG: begin
        tkind = REG;
        tdata = head_s.rdata;
        tinfo = reg_tinfo(head_s.raddr);
      end
      SEL_INSTR: begin
        tkind = INSTR;
        taddr = head_s.addr;
        tdata = head_s.instr;
      end
      default: begin
        tkind = INSTR;
      end
    endcase
  end

  // loss accounting; a drop on the clearing edge is recorded after the clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= {CNT_W{1'b0}};
    end else if (ovf_clr) begin
      overflow   <= drop_s;
      drop_count <= CNT_W'(drop_s);
    end else if (drop_s) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) begin
        drop_count <= drop_count + CNT_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_fwrisc_trace_arbiter.sv
// Directed bench for fwrisc_trace_arbiter: a bundle/beat queue model checked
// every cycle, plus hand-computed literal expectations for key scenarios.
module tb_fwrisc_trace_arbiter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              en, ovf_clr, ivalid, rwrite, mvalid, mwrite, tready;
  logic [31:0]       addr, instr, rdata, maddr, mdata;
  logic [5:0]        raddr;
  logic [3:0]        mstrb;
  logic              tvalid;
  logic [1:0]        tkind;
  logic [31:0]       taddr, tdata;
  logic [7:0]        tinfo;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;

  always #5 clock = ~clock;

  fwrisc_trace_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .en(en), .ovf_clr(ovf_clr),
    .ivalid(ivalid), .addr(addr), .instr(instr),
    .rwrite(rwrite), .raddr(raddr), .rdata(rdata),
    .mvalid(mvalid), .mwrite(mwrite), .maddr(maddr), .mdata(mdata), .mstrb(mstrb),
    .tvalid(tvalid), .tready(tready), .tkind(tkind), .taddr(taddr),
    .tdata(tdata), .tinfo(tinfo), .overflow(overflow), .drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // model: expected beats in stream order, each tagged with end-of-bundle
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  info;
    bit          last;
  } beat_t;

  beat_t mq[$];
  int    m_nb;
  bit    m_ovf;
  int    m_cnt;

  task automatic model_clear();
    mq.delete();
    m_nb  = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_update();
    bit drop;
    bit popb;
    drop = 1'b0;
    popb = 1'b0;
    if (mq.size() > 0 && tready) begin
      popb = mq[0].last;
      void'(mq.pop_front());
      if (popb) m_nb--;
    end
    if (en && (ivalid || rwrite || mvalid)) begin
      if (m_nb < DEPTH) begin
        if (mvalid) mq.push_back('{2'd2, maddr, mdata, {3'b000, mwrite, mstrb}, 1'b0});
        if (rwrite) mq.push_back('{2'd1, 32'h0, rdata, {2'b00, raddr}, 1'b0});
        if (ivalid) mq.push_back('{2'd0, addr, instr, 8'h00, 1'b0});
        mq[mq.size()-1].last = 1'b1;
        m_nb++;
      end else begin
        drop = 1'b1;
      end
    end
    if (ovf_clr) begin
      m_ovf = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clock) begin
    if (!reset && cmp_en) begin
      chk("m_tvalid", tvalid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("m_tkind", tkind, mq[0].kind);
        chk("m_taddr", taddr, mq[0].a);
        chk("m_tdata", tdata, mq[0].d);
        chk("m_tinfo", tinfo, mq[0].info);
      end
      chk("m_overflow", overflow, m_ovf);
      chk("m_drop_count", drop_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
    #2;
  endtask

  task automatic idle();
    ivalid = 1'b0; rwrite = 1'b0; mvalid = 1'b0; mwrite = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic retire(input logic [31:0] a, input logic [31:0] i);
    idle();
    ivalid = 1'b1; addr = a; instr = i;
    tick();
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; tready = 1'b1;
    addr = 32'h0; instr = 32'h0; raddr = 6'd0; rdata = 32'h0;
    maddr = 32'h0; mdata = 32'h0; mstrb = 4'h0;
    idle();
    repeat (2) @(negedge clock);
    #2;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tkind", tkind, 2'd0);
    chk("rst_taddr", taddr, 32'h0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_tinfo", tinfo, 8'h00);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_count", drop_count, 16'h0);
    reset = 1'b0;
    model_clear();
    cmp_en = 1'b1;

    // single retire: one INSTR beat, visible the cycle after capture
    retire(32'h8000_0000, 32'h0000_0013);
    idle();
    chk("single_tvalid", tvalid, 1'b1);
    chk("single_tkind", tkind, 2'd0);
    chk("single_taddr", taddr, 32'h8000_0000);
    chk("single_tdata", tdata, 32'h0000_0013);
    chk("single_tinfo", tinfo, 8'h00);
    tick();
    chk("single_done", tvalid, 1'b0);

    // all three events: MEM, REG, INSTR back to back
    mvalid = 1'b1; mwrite = 1'b1; maddr = 32'h0000_1000; mdata = 32'hDEAD_BEEF; mstrb = 4'hF;
    rwrite = 1'b1; raddr = 6'd5; rdata = 32'h0000_002A;
    ivalid = 1'b1; addr = 32'h8000_0004; instr = 32'h0010_0093;
    tick();
    idle();
    chk("all3_mem_kind", tkind, 2'd2);
    chk("all3_mem_taddr", taddr, 32'h0000_1000);
    chk("all3_mem_tdata", tdata, 32'hDEAD_BEEF);
    chk("all3_mem_tinfo", tinfo, 8'h1F);
    tick();
    chk("all3_reg_kind", tkind, 2'd1);
    chk("all3_reg_taddr", taddr, 32'h0);
    chk("all3_reg_tdata", tdata, 32'h0000_002A);
    chk("all3_reg_tinfo", tinfo, 8'h05);
    tick();
    chk("all3_ins_kind", tkind, 2'd0);
    chk("all3_ins_taddr", taddr, 32'h8000_0004);
    tick();
    chk("all3_done", tvalid, 1'b0);

    // backpressure: 6 retires into a 4-deep FIFO drops 2
    tready = 1'b0;
    for (int i = 0; i < 6; i++) retire(32'h100 + 32'(4 * i), 32'(i));
    idle();
    chk("bp_overflow", overflow, 1'b1);
    chk("bp_drop_count", drop_count, 16'd2);
    tick();
    tick();
    chk("bp_stable_valid", tvalid, 1'b1);
    chk("bp_stable_taddr", taddr, 32'h100);
    tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_taddr", taddr, 32'h100 + 32'(4 * k));
      tick();
    end
    chk("bp_drained", tvalid, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_overflow", overflow, 1'b0);
    chk("clr_drop_count", drop_count, 16'd0);

    // full FIFO with a pop on the same edge accepts the new bundle
    tready = 1'b0;
    for (int i = 0; i < 4; i++) retire(32'h200 + 32'(4 * i), 32'h13);
    tready = 1'b1;
    retire(32'h210, 32'h13);
    idle();
    tready = 1'b0;
    chk("fullpop_drop_count", drop_count, 16'd0);
    chk("fullpop_overflow", overflow, 1'b0);
    tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fullpop_drain_taddr", taddr, 32'h204 + 32'(4 * k));
      tick();
    end
    chk("fullpop_drained", tvalid, 1'b0);

    // capture disabled
    en = 1'b0;
    retire(32'h300, 32'h13);
    idle();
    en = 1'b1;
    chk("en0_tvalid", tvalid, 1'b0);

    // drop coinciding with clear, then saturate the counter
    tready = 1'b0;
    for (int i = 0; i < 4; i++) retire(32'h400 + 32'(4 * i), 32'h13);
    ivalid = 1'b1; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clrdrop_overflow", overflow, 1'b1);
    chk("clrdrop_count", drop_count, 16'd1);
    for (int i = 0; i < 65538; i++) tick();
    idle();
    chk("sat_drop_count", drop_count, 16'hFFFF);
    chk("sat_head_taddr", taddr, 32'h400);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tready = 1'b1;
    repeat (5) tick();
    chk("sat_drained", tvalid, 1'b0);

    // reset between edges while beats are pending
    tready = 1'b0;
    retire(32'h500, 32'h13);
    retire(32'h504, 32'h13);
    idle();
    chk("rmid_pre_tvalid", tvalid, 1'b1);
    #1;
    cmp_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rmid_tvalid", tvalid, 1'b0);
    chk("rmid_taddr", taddr, 32'h0);
    model_clear();
    @(negedge clock);
    #2;
    reset = 1'b0;
    cmp_en = 1'b1;
    tready = 1'b1;
    repeat (3) tick();
    chk("rmid_no_stale", tvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
